// File: rtl/fetch_controller.sv
// Fetch-stage controller: issues sequential fetch addresses to a synchronous-read
// instruction memory, tracks the single in-flight read and buffers returned
// instructions in a 2-entry FIFO towards decode. Handles redirect, halt and
// out-of-range faults.
module fetch_controller #(
    parameter int              WORD      = 64,
    parameter int              INSTR_LEN = 32,
    parameter logic [WORD-1:0] RESET_PC  = '0,
    parameter int              IMEM_SIZE = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [WORD-1:0]      imem_addr,
    input  logic [INSTR_LEN-1:0] imem_instr,
    input  logic                 redirect,
    input  logic [WORD-1:0]      redirect_pc,
    input  logic                 halt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_LEN-1:0] out_instr,
    output logic [WORD-1:0]      out_pc,
    output logic                 fault
);

    localparam logic [WORD-1:0] IMEM_WORDS = WORD'(IMEM_SIZE);

    logic [WORD-1:0]      fetch_pc;
    logic                 rsp_valid;
    logic [WORD-1:0]      rsp_pc;
    logic [1:0]           count;
    logic [WORD-1:0]      pc0, pc1;
    logic [INSTR_LEN-1:0] instr0, instr1;
    logic                 fault_q;

    logic                 pop;
    logic                 push;
    logic [2:0]           occupancy;
    logic                 oor;
    logic                 can_issue;
    logic                 issue;

    // The two low bits of a redirect target are dropped by design.
    logic                 unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Issue/capture decisions; occupancy counts slots that will be taken after this edge.
    always_comb begin
        pop       = (count != 2'd0) && out_ready && !redirect;
        push      = rsp_valid && !redirect;
        occupancy = {1'b0, count} + {2'b00, rsp_valid} - {2'b00, pop};
        oor       = (fetch_pc >> 2) >= IMEM_WORDS;
        can_issue = !redirect && !halt && !fault_q && (occupancy <= 3'd1);
        issue     = can_issue && !oor;
    end

    // Fetch address and in-flight read tracking; redirect squashes the pending read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc  <= RESET_PC;
            rsp_valid <= 1'b0;
            rsp_pc    <= '0;
        end else if (redirect) begin
            fetch_pc  <= {redirect_pc[WORD-1:2], 2'b00};
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= issue;
            if (issue) begin
                rsp_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + WORD'(4);
            end
        end
    end

    // Sticky out-of-range flag, raised only when a fetch was otherwise allowed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= 1'b0;
        end else if (can_issue && oor) begin
            fault_q <= 1'b1;
        end
    end

    // Two-entry shifting FIFO; slot 0 is always the head presented to decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            pc0    <= '0;
            pc1    <= '0;
            instr0 <= '0;
            instr1 <= '0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        pc0    <= rsp_pc;
                        instr0 <= imem_instr;
                    end else begin
                        pc1    <= rsp_pc;
                        instr1 <= imem_instr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    pc0    <= pc1;
                    instr0 <= instr1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        pc0    <= rsp_pc;
                        instr0 <= imem_instr;
                    end else begin
                        pc0    <= pc1;
                        instr0 <= instr1;
                        pc1    <= rsp_pc;
                        instr1 <= imem_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = fetch_pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = instr0;
    assign out_pc    = pc0;
    assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a main instance (IMEM_SIZE=1024) and a
// small instance (IMEM_SIZE=4) for the out-of-range fault behaviour.
module tb_fetch_controller;

    logic        clk;
    logic        reset_n, rst_f;
    logic [63:0] imem_addr, imem_addr_f;
    logic [31:0] imem_instr, imem_instr_f;
    logic        redirect, redirect_f;
    logic [63:0] redirect_pc, redirect_pc_f;
    logic        halt, halt_f;
    logic        out_valid, out_valid_f;
    logic        out_ready, ready_f;
    logic [31:0] out_instr, out_instr_f;
    logic [63:0] out_pc, out_pc_f;
    logic        fault, fault_f;

    int checks = 0;
    int passes = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_qf[$];
    logic [63:0] e_main, e_f;

    fetch_controller #(.WORD(64), .INSTR_LEN(32), .RESET_PC(64'd0), .IMEM_SIZE(1024)) dut (
        .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault)
    );

    fetch_controller #(.WORD(64), .INSTR_LEN(32), .RESET_PC(64'd0), .IMEM_SIZE(4)) dut_f (
        .clk(clk), .reset_n(rst_f), .imem_addr(imem_addr_f), .imem_instr(imem_instr_f),
        .redirect(redirect_f), .redirect_pc(redirect_pc_f), .halt(halt_f),
        .out_valid(out_valid_f), .out_ready(ready_f), .out_instr(out_instr_f),
        .out_pc(out_pc_f), .fault(fault_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        return 32'hA000_0000 + 32'(pc >> 2);
    endfunction

    // Synchronous-read memories: word i holds A0000000+i.
    always @(posedge clk) imem_instr   <= word_at(imem_addr);
    always @(posedge clk) imem_instr_f <= word_at(imem_addr_f);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pcs(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 64'(4 * i));
    endtask

    task automatic expect_pcs_f(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) exp_qf.push_back(first + 64'(4 * i));
    endtask

    // Main monitor: every transfer must match the next expected entry.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL main_unexpected: got pc %h expected no transfer", out_pc);
            end else begin
                e_main = exp_q.pop_front();
                if (out_pc === e_main && out_instr === word_at(e_main)) passes++;
                else $display("FAIL main_xfer: got pc %h instr %h expected pc %h instr %h",
                              out_pc, out_instr, e_main, word_at(e_main));
            end
        end
    end

    // Fault-instance monitor.
    always @(negedge clk) begin
        if (rst_f && out_valid_f && ready_f && !redirect_f) begin
            checks++;
            if (exp_qf.size() == 0) begin
                $display("FAIL f_unexpected: got pc %h expected no transfer", out_pc_f);
            end else begin
                e_f = exp_qf.pop_front();
                if (out_pc_f === e_f && out_instr_f === word_at(e_f)) passes++;
                else $display("FAIL f_xfer: got pc %h instr %h expected pc %h instr %h",
                              out_pc_f, out_instr_f, e_f, word_at(e_f));
            end
        end
    end

    initial begin
        reset_n = 1'b0; rst_f = 1'b0;
        out_ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ready_f = 1'b1; halt_f = 1'b0; redirect_f = 1'b0; redirect_pc_f = '0;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        tick(2);

        // Streaming from reset, then backpressure while pc 8 is at the head.
        expect_pcs(64'd0, 6);
        reset_n = 1'b1;
        tick(1);
        chk("c1_out_valid", 64'(out_valid), 64'd0);
        tick(1);
        chk("c2_out_valid", 64'(out_valid), 64'd1);
        chk("c2_out_pc", out_pc, 64'd0);
        tick(2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_pc", out_pc, 64'd8);
            chk("bp_out_instr", 64'(out_instr), 64'hA000_0002);
            tick(1);
        end
        out_ready = 1'b1;
        tick(4);

        // Redirect to 0x103 with a buffered entry and a read in flight.
        expect_pcs(64'h100, 5);
        redirect = 1'b1; redirect_pc = 64'h103;
        tick(1);
        redirect = 1'b0;
        chk("rd_c1_out_valid", 64'(out_valid), 64'd0);
        tick(1);
        chk("rd_c2_out_valid", 64'(out_valid), 64'd0);
        tick(1);
        chk("rd_out_valid", 64'(out_valid), 64'd1);
        chk("rd_out_pc", out_pc, 64'h100);
        chk("rd_out_instr", 64'(out_instr), 64'hA000_0040);
        tick(3);

        // Halt for 4 cycles in a steady stream.
        halt = 1'b1;
        tick(2);
        chk("halt_drained_a", 64'(out_valid), 64'd0);
        tick(1);
        chk("halt_drained_b", 64'(out_valid), 64'd0);
        tick(1);
        halt = 1'b0;
        expect_pcs(64'h114, 3);
        chk("halt_rel_c0", 64'(out_valid), 64'd0);
        tick(1);
        chk("halt_rel_c1", 64'(out_valid), 64'd0);
        tick(1);
        chk("halt_resume_valid", 64'(out_valid), 64'd1);
        chk("halt_resume_pc", out_pc, 64'h114);
        tick(3);

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_fault", 64'(fault), 64'd0);
        chk("arst_out_pc", out_pc, 64'd0);
        chk("arst_imem_addr", imem_addr, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_pcs(64'd0, 4);
        reset_n = 1'b1;
        tick(1);
        chk("arst_c1_out_valid", 64'(out_valid), 64'd0);
        tick(1);
        chk("arst_restart_pc", out_pc, 64'd0);
        tick(2);
        halt = 1'b1;
        tick(2);
        chk("end_out_valid", 64'(out_valid), 64'd0);
        tick(3);
        chk("main_queue_empty", 64'(exp_q.size()), 64'd0);

        // Out-of-range fault on the IMEM_SIZE=4 instance.
        expect_pcs_f(64'd0, 4);
        rst_f = 1'b1;
        tick(4);
        chk("f_c4_fault", 64'(fault_f), 64'd0);
        tick(1);
        chk("f_fault_set", 64'(fault_f), 64'd1);
        tick(1);
        chk("f_out_valid_low", 64'(out_valid_f), 64'd0);
        tick(2);
        chk("f_fault_sticky", 64'(fault_f), 64'd1);
        chk("f_still_idle", 64'(out_valid_f), 64'd0);
        chk("f_queue_drained", 64'(exp_qf.size()), 64'd0);
        expect_pcs_f(64'd0, 4);
        redirect_f = 1'b1; redirect_pc_f = 64'd0;
        tick(1);
        redirect_f = 1'b0;
        chk("f_fault_cleared", 64'(fault_f), 64'd0);
        tick(2);
        chk("f_restart_valid", 64'(out_valid_f), 64'd1);
        chk("f_restart_pc", out_pc_f, 64'd0);
        tick(6);
        chk("f_fault_again", 64'(fault_f), 64'd1);
        chk("f_end_idle", 64'(out_valid_f), 64'd0);
        chk("f_queue_empty", 64'(exp_qf.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
